// File: rtl/fifo_multi_line_buffer_if.sv
// Pixel stream bundle for the multi-line buffer.
// Ports: we_i/data_i in; taps_o/valid_o/col_o/done_o out.
interface fifo_multi_line_buffer_if #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int NUM_LINES = 2
) ();
    logic                            we_i;
    logic [DATA_W-1:0]               data_i;
    logic [(NUM_LINES+1)*DATA_W-1:0] taps_o;
    logic                            valid_o;
    logic [$clog2(IMG_W)-1:0]        col_o;
    logic                            done_o;

    modport master (
        output we_i,
        output data_i,
        input  taps_o,
        input  valid_o,
        input  col_o,
        input  done_o
    );

    modport slave (
        input  we_i,
        input  data_i,
        output taps_o,
        output valid_o,
        output col_o,
        output done_o
    );
endinterface

// File: rtl/fifo_multi_line_buffer.sv
// Multi-line raster buffer producing vertical pixel column taps.
// Ports: clk, rst (sync, active-high), clear_i, bus (slave: we_i,
// data_i, taps_o, valid_o, col_o, done_o).
module fifo_multi_line_buffer #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 640,
    parameter int NUM_LINES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    fifo_multi_line_buffer_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int LW = $clog2(NUM_LINES + 1);
    localparam int TW = (NUM_LINES + 1) * DATA_W;

    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
    localparam logic [LW-1:0] LINES_MAX = LW'(NUM_LINES);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    logic [DATA_W-1:0] mem_q [NUM_LINES][IMG_W];

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [CW-1:0]   col_d;
    logic [LW-1:0]   lines_q;
    logic [LW-1:0]   lines_d;
    logic [TW-1:0]   taps_q;
    logic [TW-1:0]   taps_d;
    logic [CW-1:0]   col_o_q;
    logic            valid_q;
    logic            done_q;
    logic            wr;
    logic            wrap;

    // clear_i swallows any write presented in the same cycle
    assign wr   = bus.we_i & ~clear_i;
    assign wrap = (col_q == COL_MAX);

    always_comb begin
        col_d   = wrap ? '0 : col_q + CW'(1);
        lines_d = lines_q + LW'(1);
        taps_d  = '0;
        taps_d[0 +: DATA_W] = bus.data_i;
        // Row k sees the pixel that sat k lines above in this column
        for (int k = 1; k <= NUM_LINES; k++) begin
            taps_d[k*DATA_W +: DATA_W] = mem_q[k-1][col_q];
        end
    end

    // Line memories shift down one row per write at the current column
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem_q[0][col_q] <= bus.data_i;
            for (int k = 1; k < NUM_LINES; k++) begin
                mem_q[k][col_q] <= mem_q[k-1][col_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q <= FILL;
            col_q   <= '0;
            lines_q <= '0;
            taps_q  <= '0;
            col_o_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (wr) begin
            col_q   <= col_d;
            taps_q  <= taps_d;
            col_o_q <= col_q;
            done_q  <= wrap;
            valid_q <= (state_q == RUN);
            case (state_q)
                FILL: begin
                    if (wrap) begin
                        lines_q <= lines_d;
                        if (lines_d == LINES_MAX) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

    assign bus.taps_o  = taps_q;
    assign bus.valid_o = valid_q;
    assign bus.col_o   = col_o_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_fifo_multi_line_buffer.sv
// Directed bench for fifo_multi_line_buffer (8-bit, 4-wide, 2 lines).
// Drives the pixel bus through the interface and checks each step.
module tb_fifo_multi_line_buffer;
    logic clk;
    logic rst;
    logic clr;
    int   tests;
    int   fails;

    fifo_multi_line_buffer_if #(
        .DATA_W(8), .IMG_W(4), .NUM_LINES(2)
    ) bus ();

    fifo_multi_line_buffer #(
        .DATA_W(8), .IMG_W(4), .NUM_LINES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clear_i(clr),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(input logic w,
                        input logic [7:0] d,
                        input logic c);
        bus.we_i   = w;
        bus.data_i = d;
        clr        = c;
        @(posedge clk);
        #1;
        bus.we_i = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_taps"},  32'(bus.taps_o),  32'h0);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
        chk({tag, "_col"},   32'(bus.col_o),   32'h0);
        chk({tag, "_done"},  32'(bus.done_o),  32'h0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst        = 1'b1;
        clr        = 1'b0;
        bus.we_i   = 1'b0;
        bus.data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Fill two lines: never valid, done at line ends
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_valid", 32'(bus.valid_o), 32'h0);
            chk("fill_col", 32'(bus.col_o), 32'(i % 4));
            chk("fill_done", 32'(bus.done_o), 32'(i % 4 == 3));
            chk("fill_tap0", 32'(bus.taps_o[7:0]), 32'(i));
        end

        // First primed line with idle gaps between writes
        step(1'b1, 8'd8, 1'b0);
        chk("w8_valid", 32'(bus.valid_o), 32'h1);
        chk("w8_taps", 32'(bus.taps_o), 32'h00_04_08);
        chk("w8_col", 32'(bus.col_o), 32'h0);
        chk("w8_done", 32'(bus.done_o), 32'h0);
        step(1'b0, 8'hEE, 1'b0);
        chk("gap_valid", 32'(bus.valid_o), 32'h0);
        chk("gap_taps", 32'(bus.taps_o), 32'h00_04_08);
        chk("gap_col", 32'(bus.col_o), 32'h0);
        step(1'b1, 8'd9, 1'b0);
        chk("w9_valid", 32'(bus.valid_o), 32'h1);
        chk("w9_taps", 32'(bus.taps_o), 32'h01_05_09);
        chk("w9_col", 32'(bus.col_o), 32'h1);
        step(1'b0, 8'hEE, 1'b0);
        step(1'b0, 8'hEE, 1'b0);
        chk("gap2_valid", 32'(bus.valid_o), 32'h0);
        chk("gap2_done", 32'(bus.done_o), 32'h0);
        chk("gap2_taps", 32'(bus.taps_o), 32'h01_05_09);
        step(1'b1, 8'd10, 1'b0);
        chk("w10_taps", 32'(bus.taps_o), 32'h02_06_0A);
        chk("w10_col", 32'(bus.col_o), 32'h2);
        step(1'b1, 8'd11, 1'b0);
        chk("w11_taps", 32'(bus.taps_o), 32'h03_07_0B);
        chk("w11_done", 32'(bus.done_o), 32'h1);
        chk("w11_valid", 32'(bus.valid_o), 32'h1);
        step(1'b0, 8'hEE, 1'b0);
        chk("post_done", 32'(bus.done_o), 32'h0);

        // Soft clear with a concurrent write mid-line
        step(1'b1, 8'hA0, 1'b1);
        chk_zero("clr0");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
        end
        chk("pre_clr_col", 32'(bus.col_o), 32'h1);
        step(1'b1, 8'hAA, 1'b1);
        chk_zero("clr1");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0);
            chk("clr_fill_valid", 32'(bus.valid_o), 32'h0);
            chk("clr_fill_col", 32'(bus.col_o), 32'(i % 4));
        end
        step(1'b1, 8'h28, 1'b0);
        chk("clr_w9_valid", 32'(bus.valid_o), 32'h1);
        chk("clr_w9_col", 32'(bus.col_o), 32'h0);
        chk("clr_w9_taps", 32'(bus.taps_o), 32'h20_24_28);
        step(1'b1, 8'h29, 1'b0);
        step(1'b1, 8'h2A, 1'b0);
        chk("clr_w11_taps", 32'(bus.taps_o), 32'h22_26_2A);

        // Hard reset in RUN beats a concurrent write
        rst = 1'b1;
        step(1'b1, 8'h55, 1'b1);
        rst = 1'b0;
        chk_zero("rst_run");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0);
            chk("rst_fill_valid", 32'(bus.valid_o), 32'h0);
            chk("rst_fill_done", 32'(bus.done_o), 32'(i % 4 == 3));
            chk("rst_fill_col", 32'(bus.col_o), 32'(i % 4));
        end
        step(1'b1, 8'h38, 1'b0);
        chk("rst_w9_valid", 32'(bus.valid_o), 32'h1);
        chk("rst_w9_taps", 32'(bus.taps_o), 32'h30_34_38);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_multi_line_buffer.md
FIFO_MULTI_LINE_BUFFER -- requirements
Module: fifo_multi_line_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per image line (>=2).
REQ-003 SHALL have parameter NUM_LINES, default 2, number of buffered full lines (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear, active-high.
REQ-007 SHALL have port we_i  input  1  pixel write strobe.
REQ-008 SHALL have port data_i  input  DATA_W  incoming pixel, raster order.
REQ-009 SHALL have port taps_o  output  (NUM_LINES+1)*DATA_W  vertical column taps; tap k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port valid_o  output  1  taps_o holds a fully primed column.
REQ-011 SHALL have port col_o  output  $clog2(IMG_W)  column of the pixel on tap 0.
REQ-012 SHALL have port done_o  output  1  end-of-line pulse.

Function
REQ-013 SHALL hold NUM_LINES circular line memories of IMG_W x DATA_W, sharing one write column counter col (0..IMG_W-1).
REQ-014 On an accepted write (we_i=1, clear_i=0), SHALL in the same edge: read old mem_k[col] for all k, write mem_0[col]<=data_i, write mem_k[col]<=old mem_{k-1}[col] for k>=1.
REQ-015 Latency: SHALL register taps_o one cycle after the accepted write; tap 0 = data_i, tap k = old mem_{k-1}[col] = pixel written k*IMG_W writes earlier.
REQ-016 SHALL hold taps_o, col_o, and all memories unchanged in cycles with we_i=0; valid_o and done_o SHALL be 0 in such cycles.
REQ-017 col SHALL increment per accepted write and wrap from IMG_W-1 to 0; col_o SHALL present the col value used by the write now shown on taps_o.
REQ-018 done_o SHALL pulse for exactly one cycle, registered with taps_o, after each accepted write at col=IMG_W-1.
REQ-019 SHALL implement FSM FILL/RUN with line counter lines (0..NUM_LINES): FILL increments lines at each column wrap; FILL->RUN on the wrap that makes lines=NUM_LINES; RUN holds until rst or clear_i.
REQ-020 valid_o SHALL be 1 for one cycle, registered with taps_o, after each accepted write made in RUN state (i.e. write index >= NUM_LINES*IMG_W since reset/clear).
REQ-021 clear_i=1 SHALL return col, lines, FSM to reset values, force valid_o=0, done_o=0, taps_o=0, leave memories unchanged, and discard any simultaneous we_i.
REQ-022 Memory contents after reset/clear are don't-care; taps_o bits for unprimed rows carry no meaning while valid_o=0.
REQ-023 Widths SHALL be exact; no arithmetic on pixel data, pass-through only.

Reset
REQ-024 rst=1 at a rising edge SHALL set taps_o=0, valid_o=0, col_o=0, done_o=0, col=0, lines=0, state=FILL; rst SHALL have priority over clear_i and we_i.
REQ-025 Reset mid-line or mid-frame SHALL abandon the partial line; next accepted write SHALL be treated as col 0 of line 0 of a new FILL.
REQ-026 Memories SHALL require no reset.

Verification (DATA_W=8, IMG_W=4, NUM_LINES=2)
REQ-027 Reset then write 0..7 continuously -> valid_o=0 throughout; done_o pulses after writes of 3 and 7; col_o cycles 0,1,2,3,0,1,2,3.
REQ-028 Continue writing 8..11 -> cycle after write 8: valid_o=1, taps_o taps {0:8, 1:4, 2:0}, col_o=0; after write 11: taps {11,7,3}, done_o=1.
REQ-029 Insert we_i=0 gaps between writes in REQ-028 -> taps_o/col_o held, valid_o=0 in gap cycles, same tap values on resume.
REQ-030 Assert clear_i with we_i=1 after write 5 -> that write discarded; next 8 writes give valid_o=0; 9th write gives valid_o=1, col_o=0.
REQ-031 Assert rst after write 10 in RUN -> all outputs 0 next cycle; following 8 writes give valid_o=0, done_o after 4th and 8th.
